addr_to_cart: RTL and testbench

Registered address-to-coordinate converter for the 640×480 VGA frame path. It takes the linear pixel address produced by the VGA scan controller and returns the pixel's column (x) and row (y). Overlay and processor blocks use these coordinates for their region tests. It sits between the scan address counter and every screen-composition block, and adds exactly one clock of latency.

---
 rtl/vga_pkg.sv | 14 +
 rtl/addr_to_cart_if.sv | 28 ++
 rtl/div5_u12.sv | 23 ++
 rtl/addr_to_cart.sv | 89 ++++++++
 tb/tb_addr_to_cart.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA frame geometry for the 640x480 pixel path.
// Holds the frame constants and the coordinate type used by every
// screen-composition block. No ports.
package vga_pkg;

  localparam int unsigned H_RES        = 640;
  localparam int unsigned V_RES        = 480;
  localparam int unsigned FRAME_PIXELS = H_RES * V_RES;  // 307200
  localparam int unsigned ADDR_W       = 19;
  localparam int unsigned COORD_W      = 10;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/addr_to_cart_if.sv
// Address-in / coordinate-out bundle for addr_to_cart.
//   curAddress  linear pixel address (y*640 + x)
//   addrValid   qualifies curAddress
//   curX/curY   registered column/row
//   coordValid  addrValid delayed one cycle
//   outOfRange  address beyond the visible frame (range-check builds only)
// master: the scan side that drives addresses; slave: the converter.
interface addr_to_cart_if;
  import vga_pkg::*;

  logic [ADDR_W-1:0] curAddress;
  logic              addrValid;
  coord_t            curX;
  coord_t            curY;
  logic              coordValid;
  logic              outOfRange;

  modport master (
    output curAddress, addrValid,
    input  curX, curY, coordValid, outOfRange
  );

  modport slave (
    input  curAddress, addrValid,
    output curX, curY, coordValid, outOfRange
  );

endinterface

// File: rtl/div5_u12.sv
// Combinational unsigned divide-by-5 of a 12-bit value, 10-bit quotient.
//   dividend_i  12-bit unsigned dividend (0..4095)
//   quotient_o  floor(dividend_i / 5), 0..819
// 819/4096 slightly underestimates 1/5, so the estimate is either exact
// or one short; a single remainder test fixes the short case.
module div5_u12
  import vga_pkg::*;
(
  input  logic [11:0] dividend_i,
  output coord_t      quotient_o
);

  logic [21:0] prod;
  coord_t      q_est;
  logic [12:0] rem;

  assign prod  = {10'd0, dividend_i} * 22'd819;
  assign q_est = coord_t'(prod >> 12);
  assign rem   = {1'b0, dividend_i} - ({3'd0, q_est} * 13'd5);

  assign quotient_o = q_est + {9'd0, (rem >= 13'd5)};

endmodule

// File: rtl/addr_to_cart.sv
// Registered linear-address to (x, y) converter for the 640x480 frame.
// One clock of latency, one address per clock, no back-pressure.
//   clock   system clock, rising edge
//   resetn  synchronous active-low reset
//   bus     addr_to_cart_if.slave (curAddress/addrValid in,
//           curX/curY/coordValid/outOfRange out)
// Build option ADDR_TO_CART_RANGE_CHECK_EN: flags addresses past the
// visible frame on outOfRange and zeroes their coordinates. Without it
// outOfRange is tied low and out-of-frame addresses give raw q/r.
module addr_to_cart
  import vga_pkg::*;
(
  input  logic           clock,
  input  logic           resetn,
  addr_to_cart_if.slave  bus
);

  coord_t            q;
  coord_t            r;
  logic [ADDR_W-1:0] q_x640;
  logic [ADDR_W-1:0] rem_full;
  coord_t            x_d, y_d;
  coord_t            x_q, y_q;
  logic              valid_q;

  // a/640 == (a/128)/5, so only the upper 12 bits go through the divider.
  div5_u12 u_div5 (
    .dividend_i (bus.curAddress[ADDR_W-1:7]),
    .quotient_o (q)
  );

  // q*640 as q*512 + q*128.
  assign q_x640   = ({9'd0, q} << 9) + ({9'd0, q} << 7);
  assign rem_full = bus.curAddress - q_x640;
  assign r        = coord_t'(rem_full);

`ifdef ADDR_TO_CART_RANGE_CHECK_EN
  logic oor;
  logic oor_q;

  assign oor = (bus.curAddress >= ADDR_W'(FRAME_PIXELS));

  always_comb begin
    x_d = r;
    y_d = q;
    if (oor) begin
      x_d = '0;
      y_d = '0;
    end
  end

  // Held with the coordinates it describes when addrValid is low.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      oor_q <= 1'b0;
    end else if (bus.addrValid) begin
      oor_q <= oor;
    end
  end

  assign bus.outOfRange = oor_q;
`else
  always_comb begin
    x_d = r;
    y_d = q;
  end

  assign bus.outOfRange = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.addrValid;
      if (bus.addrValid) begin
        x_q <= x_d;
        y_q <= y_d;
      end
    end
  end

  assign bus.curX       = x_q;
  assign bus.curY       = y_q;
  assign bus.coordValid = valid_q;

endmodule

// File: tb/tb_addr_to_cart.sv
// Directed bench for addr_to_cart. Inputs change on the falling edge;
// outputs are read on the falling edge after the capturing rising edge.
module tb_addr_to_cart;
  import vga_pkg::*;

  logic clock;
  logic resetn;
  int   tests;
  int   fails;

  addr_to_cart_if bus ();

  addr_to_cart dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef ADDR_TO_CART_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  task automatic test_reset();
    resetn = 1'b0;
    bus.addrValid  = 1'b1;
    bus.curAddress = 19'd1234;
    repeat (2) @(negedge clock);
    tests++;
    if (bus.curX !== 10'd0) begin fails++; $display("FAIL reset_x got %0d want 0", bus.curX); end
    tests++;
    if (bus.curY !== 10'd0) begin fails++; $display("FAIL reset_y got %0d want 0", bus.curY); end
    tests++;
    if (bus.coordValid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bus.coordValid); end
    tests++;
    if (bus.outOfRange !== 1'b0) begin fails++; $display("FAIL reset_oor got %b want 0", bus.outOfRange); end
    bus.addrValid = 1'b0;
    resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_corners();
    logic [18:0] a  [4] = '{19'd0, 19'd639, 19'd640, 19'd307199};
    logic [9:0]  ex [4] = '{10'd0, 10'd639, 10'd0, 10'd639};
    logic [9:0]  ey [4] = '{10'd0, 10'd0, 10'd1, 10'd479};
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        tests++;
        if (bus.curX !== ex[i-1] || bus.curY !== ey[i-1] || bus.coordValid !== 1'b1
            || bus.outOfRange !== 1'b0) begin
          fails++;
          $display("FAIL corner addr=%0d got (%0d,%0d) v=%b oor=%b want (%0d,%0d) v=1 oor=0",
                   a[i-1], bus.curX, bus.curY, bus.coordValid, bus.outOfRange, ex[i-1], ey[i-1]);
        end
      end
      if (i < 4) begin bus.curAddress = a[i]; bus.addrValid = 1'b1; end
      else bus.addrValid = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic test_anchors();
    logic [18:0] a  [3] = '{19'd102435, 19'd119342, 19'd202556};
    logic [9:0]  ex [3] = '{10'd35, 10'd302, 10'd316};
    logic [9:0]  ey [3] = '{10'd160, 10'd186, 10'd316};
    for (int i = 0; i <= 3; i++) begin
      if (i > 0) begin
        tests++;
        if (bus.curX !== ex[i-1] || bus.curY !== ey[i-1] || bus.coordValid !== 1'b1) begin
          fails++;
          $display("FAIL anchor addr=%0d got (%0d,%0d) v=%b want (%0d,%0d) v=1",
                   a[i-1], bus.curX, bus.curY, bus.coordValid, ex[i-1], ey[i-1]);
        end
      end
      if (i < 3) begin bus.curAddress = a[i]; bus.addrValid = 1'b1; end
      else bus.addrValid = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic test_out_of_range();
    logic [18:0] a  [2] = '{19'd307200, 19'd524287};
    logic [9:0]  ex [2];
    logic [9:0]  ey [2];
    logic        eo;
    if (RC) begin
      ex = '{10'd0, 10'd0};   ey = '{10'd0, 10'd0};     eo = 1'b1;
    end else begin
      ex = '{10'd0, 10'd127}; ey = '{10'd480, 10'd819}; eo = 1'b0;
    end
    for (int i = 0; i <= 2; i++) begin
      if (i > 0) begin
        tests++;
        if (bus.curX !== ex[i-1] || bus.curY !== ey[i-1] || bus.coordValid !== 1'b1
            || bus.outOfRange !== eo) begin
          fails++;
          $display("FAIL oor addr=%0d got (%0d,%0d) v=%b oor=%b want (%0d,%0d) v=1 oor=%b",
                   a[i-1], bus.curX, bus.curY, bus.coordValid, bus.outOfRange,
                   ex[i-1], ey[i-1], eo);
        end
      end
      if (i < 2) begin bus.curAddress = a[i]; bus.addrValid = 1'b1; end
      else bus.addrValid = 1'b0;
      @(negedge clock);
    end
    // An in-range address must clear the flag again.
    bus.curAddress = 19'd5; bus.addrValid = 1'b1;
    @(negedge clock);
    bus.addrValid = 1'b0;
    tests++;
    if (bus.curX !== 10'd5 || bus.curY !== 10'd0 || bus.outOfRange !== 1'b0) begin
      fails++;
      $display("FAIL oor_clear got (%0d,%0d) oor=%b want (5,0) oor=0",
               bus.curX, bus.curY, bus.outOfRange);
    end
    @(negedge clock);
  endtask

  task automatic test_hold();
    bus.curAddress = 19'd640; bus.addrValid = 1'b1;
    @(negedge clock);
    tests++;
    if (bus.curX !== 10'd0 || bus.curY !== 10'd1 || bus.coordValid !== 1'b1) begin
      fails++;
      $display("FAIL hold_load got (%0d,%0d) v=%b want (0,1) v=1", bus.curX, bus.curY, bus.coordValid);
    end
    bus.curAddress = 19'd2000; bus.addrValid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      tests++;
      if (bus.curX !== 10'd0 || bus.curY !== 10'd1 || bus.coordValid !== 1'b0) begin
        fails++;
        $display("FAIL hold_cycle%0d got (%0d,%0d) v=%b want (0,1) v=0",
                 i, bus.curX, bus.curY, bus.coordValid);
      end
    end
  endtask

  task automatic test_reset_midstream();
    bus.curAddress = 19'd1000; bus.addrValid = 1'b1;
    @(negedge clock);
    tests++;
    if (bus.curX !== 10'd360 || bus.curY !== 10'd1 || bus.coordValid !== 1'b1) begin
      fails++;
      $display("FAIL mid_pre got (%0d,%0d) v=%b want (360,1) v=1", bus.curX, bus.curY, bus.coordValid);
    end
    bus.curAddress = 19'd1001; resetn = 1'b0;
    @(negedge clock);
    tests++;
    if (bus.curX !== 10'd0 || bus.curY !== 10'd0 || bus.coordValid !== 1'b0
        || bus.outOfRange !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset got (%0d,%0d) v=%b oor=%b want (0,0) v=0 oor=0",
               bus.curX, bus.curY, bus.coordValid, bus.outOfRange);
    end
    resetn = 1'b1; bus.curAddress = 19'd2000;
    @(negedge clock);
    bus.addrValid = 1'b0;
    tests++;
    if (bus.curX !== 10'd80 || bus.curY !== 10'd3 || bus.coordValid !== 1'b1) begin
      fails++;
      $display("FAIL mid_post got (%0d,%0d) v=%b want (80,3) v=1", bus.curX, bus.curY, bus.coordValid);
    end
    @(negedge clock);
  endtask

  // Four full rows, a stride-97 pass across the frame, and the last 1200 pixels.
  function automatic int sweep_addr(int i);
    if (i < 2560)             return i;
    else if (i < 2560 + 3167) return (i - 2560) * 97;
    else                      return 306000 + (i - 5727);
  endfunction

  task automatic test_back_to_back();
    localparam int N = 6927;
    int pa;
    int shown;
    int ex, ey;
    shown = 0;
    pa = 0;
    for (int i = 0; i <= N; i++) begin
      if (i > 0) begin
        ex = pa % 640;
        ey = pa / 640;
        tests++;
        if (int'(bus.curX) != ex || int'(bus.curY) != ey || bus.coordValid !== 1'b1
            || bus.outOfRange !== 1'b0) begin
          fails++;
          if (shown < 10) begin
            shown++;
            $display("FAIL sweep addr=%0d got (%0d,%0d) v=%b oor=%b want (%0d,%0d) v=1 oor=0",
                     pa, bus.curX, bus.curY, bus.coordValid, bus.outOfRange, ex, ey);
          end
        end
        tests++;
        if (!(bus.curX <= 10'd639)) begin
          fails++;
          if (shown < 10) begin
            shown++;
            $display("FAIL sweep_xmax addr=%0d got x=%0d want <=639", pa, bus.curX);
          end
        end
      end
      if (i < N) begin
        pa = sweep_addr(i);
        bus.curAddress = 19'(pa);
        bus.addrValid  = 1'b1;
      end else begin
        bus.addrValid = 1'b0;
      end
      @(negedge clock);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    resetn = 1'b0;
    bus.curAddress = '0;
    bus.addrValid  = 1'b0;
    @(negedge clock);
    test_reset();
    test_corners();
    test_anchors();
    test_out_of_range();
    test_hold();
    test_reset_midstream();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
